// File: rtl/nes_pad_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nes_pkg
// Brief    : Shared NES pad constants, FSM state encoding and turbo helper,
//            common to the console-side responder and the input-side receiver.
// Revision : 1.0 - initial release
// ============================================================================
package nes_pkg;

    localparam int NES_NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int             NES_CNT_W          = 4;
    localparam logic [NES_CNT_W-1:0] NES_BITS_PER_FRAME = 4'd8;
    localparam logic [NES_CNT_W-1:0] NES_LAST_BIT       = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } nes_state_e;

    // A and B are suppressed during the "off" half of the turbo cycle when enabled.
    function automatic logic [NES_NUM_BUTTONS-1:0] turbo_gate(
        input logic [NES_NUM_BUTTONS-1:0] buttons,
        input logic [1:0]                 mask,
        input logic                       phase
    );
        logic [NES_NUM_BUTTONS-1:0] eff;
        eff        = buttons;
        eff[BTN_A] = buttons[BTN_A] & (phase | ~mask[0]);
        eff[BTN_B] = buttons[BTN_B] & (phase | ~mask[1]);
        return eff;
    endfunction

endpackage : nes_pkg
`default_nettype wire

// File: rtl/nes_pad_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : nes_pad_responder_if
// Brief     : Console-side serial lines plus local pad state for the responder.
// Revision  : 1.0 - initial release
// ============================================================================
interface nes_pad_responder_if;
    import nes_pkg::*;

    logic                       nes_latch;
    logic                       nes_clk;
    logic [NES_NUM_BUTTONS-1:0] buttons;
    logic [1:0]                 turbo_mask;
    logic                       nes_data;
    logic                       frame_strobe;
    logic                       busy;

    // master: the console/pad environment; slave: the responder itself
    modport master (
        output nes_latch,
        output nes_clk,
        output buttons,
        output turbo_mask,
        input  nes_data,
        input  frame_strobe,
        input  busy
    );

    modport slave (
        input  nes_latch,
        input  nes_clk,
        input  buttons,
        input  turbo_mask,
        output nes_data,
        output frame_strobe,
        output busy
    );

endinterface : nes_pad_responder_if
`default_nettype wire

// File: rtl/nes_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : nes_edge_sync
// Brief    : Multi-flop synchronizer followed by a single edge-detect flop.
// Revision : 1.0 - initial release
// ============================================================================
module nes_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_d,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    // Fewer than two stages is not a safe synchronizer; clamp silently.
    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_stages-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_stages-2:0], i_d};
            r_prev <= r_sync[c_stages-1];
        end
    end

    assign o_level = r_sync[c_stages-1];
    assign o_rise  =  o_level & ~r_prev;
    assign o_fall  = ~o_level &  r_prev;

endmodule : nes_edge_sync
`default_nettype wire

// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_responder
// Brief    : NES controller emulation: latches pad state and shifts it out on
//            the console clock. Define NES_TURBO_EN to enable A/B turbo.
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter logic FILL_LEVEL   = 1'b0,
    parameter int   TURBO_PERIOD = 4
) (
    input wire logic           clk,
    input wire logic           reset,
    nes_pad_responder_if.slave bus
);

    logic w_latch_lvl;
    logic w_latch_fall;
    logic w_nclk_rise;
    logic w_unused_latch_rise;
    logic w_unused_nclk_lvl;
    logic w_unused_nclk_fall;

    nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .reset   (reset),
        .i_d     (bus.nes_latch),
        .o_level (w_latch_lvl),
        .o_rise  (w_unused_latch_rise),
        .o_fall  (w_latch_fall)
    );

    nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nclk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_d     (bus.nes_clk),
        .o_level (w_unused_nclk_lvl),
        .o_rise  (w_nclk_rise),
        .o_fall  (w_unused_nclk_fall)
    );

    nes_state_e                 r_state;
    nes_state_e                 w_state_next;
    logic [NES_NUM_BUTTONS-1:0] r_shift;
    logic [NES_NUM_BUTTONS-1:0] w_shift_next;
    logic [NES_CNT_W-1:0]       r_count;
    logic [NES_CNT_W-1:0]       w_count_next;
    logic                       r_strobe;
    logic                       w_strobe_next;
    logic                       w_frame_start;
    logic [NES_NUM_BUTTONS-1:0] w_eff;

`ifdef NES_TURBO_EN
    localparam int c_turbo_w = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    localparam logic [c_turbo_w-1:0] c_turbo_last = c_turbo_w'(TURBO_PERIOD - 1);

    logic [c_turbo_w-1:0] r_turbo_cnt;
    logic                 r_turbo_phase;

    // Turbo advances once per captured frame, not per system clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b1;
        end else if (w_frame_start) begin
            if (r_turbo_cnt == c_turbo_last) begin
                r_turbo_cnt   <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + 1'b1;
            end
        end
    end

    assign w_eff = turbo_gate(bus.buttons, bus.turbo_mask, r_turbo_phase);
`else
    logic w_unused_turbo_mask;

    assign w_eff               = bus.buttons;
    assign w_unused_turbo_mask = ^bus.turbo_mask;
`endif

    // Latch level overrides everything, which also resolves a simultaneous
    // latch-rise / clock-rise in favour of the reload.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_count_next  = r_count;
        w_strobe_next = 1'b0;
        w_frame_start = 1'b0;

        if (w_latch_lvl) begin
            w_state_next = ST_LOAD;
            w_shift_next = ~w_eff;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_latch_fall) begin
                        w_state_next  = ST_SHIFT;
                        w_count_next  = '0;
                        w_strobe_next = 1'b1;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_nclk_rise) begin
                        w_shift_next = {FILL_LEVEL, r_shift[NES_NUM_BUTTONS-1:1]};
                        if (r_count < NES_BITS_PER_FRAME) begin
                            w_count_next = r_count + 4'd1;
                        end
                        if (r_count == NES_LAST_BIT) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '1;
            r_count  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_count  <= w_count_next;
            r_strobe <= w_strobe_next;
        end
    end

    // After eight shifts the register is all FILL_LEVEL, so bit 0 doubles as DONE fill.
    assign bus.nes_data     = r_shift[0];
    assign bus.frame_strobe = r_strobe;
    assign bus.busy         = (r_state == ST_SHIFT);

endmodule : nes_pad_responder
`default_nettype wire

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for nes_latch and nes_clk (minimum 2).
REQ-002 Parameter FILL_LEVEL, default 1'b0, sets the level driven on nes_data after the 8th bit.
REQ-003 Parameter TURBO_PERIOD, default 4, sets the number of frames per turbo half-cycle.
REQ-004 Port clk, input, 1: the single system clock (50 MHz); all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port nes_latch, input, 1: console latch line, asynchronous to clk, active-high.
REQ-007 Port nes_clk, input, 1: console shift clock, asynchronous to clk, with a rising-edge shift.
REQ-008 Port buttons, input, 8: live pad state, 1 = pressed; bit order [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-009 Port turbo_mask, input, 2: turbo enable for [0]=A and [1]=B.
REQ-010 Port nes_data, output, 1: registered serial data, active-low (0 = pressed).
REQ-011 Port frame_strobe, output, 1: one-cycle pulse when a frame is captured.
REQ-012 Port busy, output, 1: high while the block is in the SHIFT state.

Function
REQ-013 nes_latch and nes_clk SHALL each pass through SYNC_STAGES flops followed by one edge-detect flop; all decisions SHALL use the synchronized signals only.
REQ-014 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-015 When the synchronized latch is high, the FSM SHALL be in LOAD from any state, and the 8-bit shift register SHALL reload ~eff_buttons every cycle.
REQ-016 In LOAD, nes_data SHALL equal ~eff_buttons[0] on the following cycle.
REQ-017 On a synchronized latch falling edge, the FSM SHALL enter SHIFT, freeze the shift register, clear the bit count to 0 and pulse frame_strobe for exactly one cycle.
REQ-018 On a synchronized nes_clk rising edge in SHIFT, the block SHALL shift right, fill the MSB with FILL_LEVEL and increment the count.
REQ-019 On the 8th rising edge, the block SHALL enter DONE.
REQ-020 In DONE, nes_data SHALL equal FILL_LEVEL, and further nes_clk edges SHALL be ignored.
REQ-021 nes_clk edges in IDLE and LOAD SHALL be ignored.
REQ-022 A latch rising edge and a nes_clk rising edge detected in the same cycle SHALL be resolved as a latch rising edge (abort and reload).
REQ-023 A latch rising edge mid-SHIFT SHALL abort the frame without a frame_strobe pulse.
REQ-024 nes_data SHALL change at most SYNC_STAGES+2 clk cycles after an external edge (≤ 80 ns at default settings).
REQ-025 busy SHALL be 1 exactly in SHIFT.
REQ-026 The bit count SHALL be 4 bits wide and SHALL saturate at 8; it SHALL never wrap.

Reset
REQ-027 While reset=0 at a clk edge: state=IDLE, shift register=8'hFF, nes_data=1, frame_strobe=0, busy=0, count=0, turbo counter=0, turbo phase=1, and synchronizer flops=0.
REQ-028 A reset asserted mid-frame SHALL discard the frame; the next valid frame SHALL begin only on a new latch high.

Configuration
REQ-029 Macro NES_TURBO_EN, when defined, SHALL count latch falling edges modulo TURBO_PERIOD and toggle the turbo phase at each wrap.
REQ-030 With NES_TURBO_EN defined, eff_buttons[i] SHALL equal buttons[i] & (phase | ~turbo_mask[i]) for i = 0 and 1; the other bits SHALL pass through unchanged.
REQ-031 Without NES_TURBO_EN, eff_buttons SHALL equal buttons, turbo_mask SHALL be ignored, and no turbo counter SHALL be synthesized.
REQ-032 The turbo_mask port SHALL be present in both builds.

Structure
REQ-033 The shared package nes_pkg SHALL hold the button index constants, NES_NUM_BUTTONS=8 and the FSM state enum; the package is shared with the input-side receiver.
REQ-034 The synchronizer and edge detect SHALL be one sub-module, nes_edge_sync (parameter SYNC_STAGES, outputs level and rise/fall pulses), instantiated twice.

Verification
REQ-035 buttons=8'b0000_0101, latch pulse 12 us, 8 nes_clk pulses with a 6 us period -> nes_data sequence 0,1,0,1,1,1,1,1, then 0 (FILL_LEVEL); one frame_strobe pulse.
REQ-036 A 9th–16th nes_clk pulse after the frame -> nes_data holds at 0 and the state stays DONE.
REQ-037 Latch re-asserted after 3 shifts with buttons=8'h80 -> nes_data=1 within 4 cycles of the synchronized latch rising edge; bit 7 appears on the 8th bit of the new frame; no strobe on the abort.
REQ-038 Latch rising edge and nes_clk rising edge in the same clk cycle -> reload wins; count=0 and busy=0.
REQ-039 reset=0 held for 1 cycle mid-SHIFT -> nes_data=1, busy=0, state IDLE; nes_clk pulses afterwards have no effect.
REQ-040 NES_TURBO_EN defined, turbo_mask=2'b01, A held, 16 frames -> A reads pressed in frames 1–4 and 9–12 and released in frames 5–8 and 13–16; B is unaffected.
